// File: rtl/cv_core_array_router.sv
// cv_core_array_router
//   Front-end between the data loader and NUM_CORES conv cores.
//   - Inbound beats are registered and steered to one core (id) or broadcast.
//   - The selected core's output returns through a 2-entry skid buffer.
//   - Output selection only switches while the skid buffer is empty.
//   - idle is the AND of all core idles, an empty buffer and no pending inbound beat.
//   - param_rd is the registered parameter slice of core id.
//   Optional: define CV_ROUTER_PERF_EN to build saturating beat/stall counters;
//   otherwise perf_beats and perf_stalls are tied to zero.
module cv_core_array_router #(
   parameter int unsigned NUM_CORES = 4,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned PARAM_W   = 13
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [7:0]                      id,
   input  logic                            broadcast,
   input  logic                            din_valid,
   input  logic [DATA_W-1:0]               din_data,
   output logic [NUM_CORES-1:0]            core_din_valid,
   output logic [DATA_W-1:0]               core_din_data,
   input  logic [NUM_CORES-1:0]            core_dout_valid,
   input  logic [NUM_CORES*DATA_W-1:0]     core_dout_data,
   output logic [NUM_CORES-1:0]            core_dout_ready,
   output logic                            dout_valid,
   input  logic                            dout_ready,
   output logic [DATA_W-1:0]               dout_data,
   input  logic [NUM_CORES-1:0]            core_idle,
   output logic                            idle,
   input  logic [NUM_CORES*8*PARAM_W-1:0]  core_param,
   output logic [8*PARAM_W-1:0]            param_rd,
   output logic [31:0]                     perf_beats,
   output logic [31:0]                     perf_stalls
);

   localparam int unsigned LP_PW = 8 * PARAM_W;

   // Inbound stage registers
   logic [NUM_CORES-1:0] r_in_valid;
   logic [DATA_W-1:0]    r_in_data;

   // Output selection and skid buffer (r_e0 is always the head)
   logic [7:0]           r_sel;
   logic [1:0]           r_cnt;
   logic [DATA_W-1:0]    r_e0;
   logic [DATA_W-1:0]    r_e1;

   // Parameter readback register
   logic [LP_PW-1:0]     r_param;

   // Decoded / muxed combinational values
   logic [NUM_CORES-1:0] w_onehot;
   logic [NUM_CORES-1:0] w_ready;
   logic                 w_sel_valid;
   logic [DATA_W-1:0]    w_sel_data;
   logic [LP_PW-1:0]     w_param_nxt;
   logic                 w_not_full;
   logic                 w_push;
   logic                 w_pop;

   assign w_not_full = (r_cnt != 2'd2);

   // Decode id/sel: out-of-range indices match no core, so they select nothing
   always_comb begin
      w_onehot    = '0;
      w_ready     = '0;
      w_sel_valid = 1'b0;
      w_sel_data  = '0;
      w_param_nxt = '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         if (id == 8'(i)) begin
            w_onehot[i] = 1'b1;
            w_param_nxt = core_param[i*LP_PW +: LP_PW];
         end
         if (r_sel == 8'(i)) begin
            w_ready[i]  = w_not_full;
            w_sel_valid = core_dout_valid[i];
            w_sel_data  = core_dout_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign w_push = w_sel_valid && w_not_full;
   assign w_pop  = (r_cnt != 2'd0) && dout_ready;

   // Inbound stage: one-cycle registered steering of the loader stream
   always_ff @(posedge clk) begin
      if (rst) begin
         r_in_valid <= '0;
         r_in_data  <= '0;
      end else begin
         if (din_valid) begin
            r_in_valid <= broadcast ? '1 : w_onehot;
            r_in_data  <= din_data;
         end else begin
            r_in_valid <= '0;
         end
      end
   end

   // Selection may only move while nothing is buffered and nothing is entering
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sel <= '0;
      end else if ((r_cnt == 2'd0) && !w_push) begin
         r_sel <= id;
      end
   end

   // Skid buffer: entries shift toward r_e0 so the head is always r_e0
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_e0  <= '0;
         r_e1  <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_cnt == 2'd0) r_e0 <= w_sel_data;
               else               r_e1 <= w_sel_data;
               r_cnt <= r_cnt + 2'd1;
            end
            2'b01: begin
               r_e0  <= r_e1;
               r_cnt <= r_cnt - 2'd1;
            end
            2'b11: begin
               // push only happens below full, so here count is 1: new beat becomes head
               if (r_cnt == 2'd1) begin
                  r_e0 <= w_sel_data;
               end else begin
                  r_e0 <= r_e1;
                  r_e1 <= w_sel_data;
               end
            end
            default: ;
         endcase
      end
   end

   // Parameter readback, reloaded every cycle from the addressed core
   always_ff @(posedge clk) begin
      if (rst) begin
         r_param <= '0;
      end else begin
         r_param <= w_param_nxt;
      end
   end

   assign core_din_valid  = r_in_valid;
   assign core_din_data   = r_in_data;
   assign core_dout_ready = w_ready;
   assign dout_valid      = (r_cnt != 2'd0);
   assign dout_data       = r_e0;
   assign param_rd        = r_param;
   assign idle            = (&core_idle) && (r_cnt == 2'd0) && (r_in_valid == '0);

`ifdef CV_ROUTER_PERF_EN
   logic [31:0] r_beats;
   logic [31:0] r_stalls;

   // Saturating transfer and stall counters, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_beats  <= '0;
         r_stalls <= '0;
      end else begin
         if (w_pop && (r_beats != '1)) r_beats <= r_beats + 32'd1;
         if ((r_cnt != 2'd0) && !dout_ready && (r_stalls != '1)) r_stalls <= r_stalls + 32'd1;
      end
   end

   assign perf_beats  = r_beats;
   assign perf_stalls = r_stalls;
`else
   assign perf_beats  = '0;
   assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_cv_core_array_router.sv
// Directed self-checking bench for cv_core_array_router (NUM_CORES=4).
module tb_cv_core_array_router;

   localparam int unsigned NC = 4;
   localparam int unsigned DW = 16;
   localparam int unsigned PW = 13;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [7:0]           id;
   logic                 broadcast;
   logic                 din_valid;
   logic [DW-1:0]        din_data;
   logic [NC-1:0]        core_din_valid;
   logic [DW-1:0]        core_din_data;
   logic [NC-1:0]        core_dout_valid;
   logic [NC*DW-1:0]     core_dout_data;
   logic [NC-1:0]        core_dout_ready;
   logic                 dout_valid;
   logic                 dout_ready;
   logic [DW-1:0]        dout_data;
   logic [NC-1:0]        core_idle;
   logic                 idle;
   logic [NC*8*PW-1:0]   core_param;
   logic [8*PW-1:0]      param_rd;
   logic [31:0]          perf_beats;
   logic [31:0]          perf_stalls;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] got [0:15];
   int n_got;
   int n_push;

   always #5 clk = ~clk;

   cv_core_array_router #(
      .NUM_CORES(NC),
      .DATA_W   (DW),
      .PARAM_W  (PW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .id             (id),
      .broadcast      (broadcast),
      .din_valid      (din_valid),
      .din_data       (din_data),
      .core_din_valid (core_din_valid),
      .core_din_data  (core_din_data),
      .core_dout_valid(core_dout_valid),
      .core_dout_data (core_dout_data),
      .core_dout_ready(core_dout_ready),
      .dout_valid     (dout_valid),
      .dout_ready     (dout_ready),
      .dout_data      (dout_data),
      .core_idle      (core_idle),
      .idle           (idle),
      .core_param     (core_param),
      .param_rd       (param_rd),
      .perf_beats     (perf_beats),
      .perf_stalls    (perf_stalls)
   );

   // field f (0=Iext .. 7=Wori) of core c
   function automatic logic [PW-1:0] fv(input int c, input int f);
      if (c == 2 && f == 6) return 13'h0ABC;
      return 13'(c * 256 + f * 16 + 1);
   endfunction

   function automatic logic [8*PW-1:0] exp_param(input int c);
      logic [8*PW-1:0] e;
      e = '0;
      if (c < int'(NC)) for (int f = 0; f < 8; f++) e[f*PW +: PW] = fv(c, f);
      return e;
   endfunction

   // Stream nb beats from one core; dout_ready rises at cycle rs. Collects pops.
   task automatic drive_stream(input int core, input logic [DW-1:0] base, input int nb,
                               input int rs, input int ncyc, input int target);
      n_got  = 0;
      n_push = 0;
      for (int c = 0; c < ncyc && n_got < target; c++) begin
         @(negedge clk);
         core_dout_valid = '0;
         if (n_push < nb) begin
            core_dout_valid[core] = 1'b1;
            core_dout_data[core*DW +: DW] = base + 16'(n_push);
         end
         dout_ready = (c >= rs);
         #1;
         if (dout_valid && dout_ready && n_got < 16) begin
            got[n_got] = dout_data;
            n_got++;
         end
         if (core_dout_valid[core] && core_dout_ready[core]) n_push++;
      end
      @(negedge clk);
      core_dout_valid = '0;
      dout_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; id = '0; broadcast = 1'b0; din_valid = 1'b0; din_data = '0;
      core_dout_valid = '0; core_dout_data = '0; dout_ready = 1'b0; core_idle = '1;
      for (int c = 0; c < int'(NC); c++)
         for (int f = 0; f < 8; f++) core_param[(c*8+f)*PW +: PW] = fv(c, f);
      repeat (2) @(negedge clk);
      checks++; if (core_din_valid !== 4'b0000) begin errors++; $display("FAIL rst_din_valid got %b exp 0000", core_din_valid); end
      checks++; if (core_din_data !== 16'h0000) begin errors++; $display("FAIL rst_din_data got %h exp 0000", core_din_data); end
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_dout_valid got %b exp 0", dout_valid); end
      checks++; if (param_rd !== '0) begin errors++; $display("FAIL rst_param_rd got %h exp 0", param_rd); end
      checks++; if (perf_beats !== 32'd0 || perf_stalls !== 32'd0) begin errors++; $display("FAIL rst_perf got %0d/%0d exp 0/0", perf_beats, perf_stalls); end
      checks++; if (core_dout_ready !== 4'b0001) begin errors++; $display("FAIL rst_ready got %b exp 0001", core_dout_ready); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %b exp 1", idle); end
      rst = 1'b0;
   endtask

   task automatic test_inbound;
      logic [7:0]    ids  [0:2];
      logic          bcs  [0:2];
      logic [DW-1:0] dats [0:2];
      logic [NC-1:0] exps [0:2];
      ids[0] = 8'd2; bcs[0] = 1'b0; dats[0] = 16'h1234; exps[0] = 4'b0100;
      ids[1] = 8'd2; bcs[1] = 1'b1; dats[1] = 16'h5678; exps[1] = 4'b1111;
      ids[2] = 8'd7; bcs[2] = 1'b0; dats[2] = 16'h9ABC; exps[2] = 4'b0000;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         id = ids[k]; broadcast = bcs[k]; din_valid = 1'b1; din_data = dats[k];
         @(negedge clk);
         din_valid = 1'b0; broadcast = 1'b0;
         checks++; if (core_din_valid !== exps[k]) begin errors++; $display("FAIL inb_valid[%0d] got %b exp %b", k, core_din_valid, exps[k]); end
         checks++; if (core_din_data !== dats[k]) begin errors++; $display("FAIL inb_data[%0d] got %h exp %h", k, core_din_data, dats[k]); end
         checks++; if (idle !== (exps[k] == 4'b0000)) begin errors++; $display("FAIL inb_idle[%0d] got %b exp %b", k, idle, exps[k] == 4'b0000); end
      end
      checks++; if (core_dout_ready !== 4'b0000) begin errors++; $display("FAIL sel_oob_ready got %b exp 0000", core_dout_ready); end
      @(negedge clk);
      checks++; if (core_din_valid !== 4'b0000) begin errors++; $display("FAIL inb_pulse got %b exp 0000", core_din_valid); end
   endtask

   task automatic test_backpressure;
      id = 8'd1;
      drive_stream(1, 16'hA001, 5, 99, 6, 99);
      checks++; if (n_push !== 2) begin errors++; $display("FAIL bp_pushed got %0d exp 2", n_push); end
      checks++; if (core_dout_ready !== 4'b0000) begin errors++; $display("FAIL bp_full_ready got %b exp 0000", core_dout_ready); end
      checks++; if (dout_valid !== 1'b1 || dout_data !== 16'hA001) begin errors++; $display("FAIL bp_head got %b/%h exp 1/a001", dout_valid, dout_data); end
      drive_stream(1, 16'hA003, 3, 0, 20, 5);
      checks++; if (n_got !== 5) begin errors++; $display("FAIL bp_count got %0d exp 5", n_got); end
      for (int k = 0; k < 5 && k < n_got; k++) begin
         checks++; if (got[k] !== 16'hA001 + 16'(k)) begin errors++; $display("FAIL bp_order[%0d] got %h exp %h", k, got[k], 16'hA001 + 16'(k)); end
      end
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b exp 0", dout_valid); end
   endtask

   task automatic test_sel_lock;
      @(negedge clk);
      id = 8'd0;
      @(negedge clk);
      core_dout_valid = 4'b0001; core_dout_data[0 +: DW] = 16'hB000; dout_ready = 1'b0;
      #1;
      checks++; if (core_dout_ready !== 4'b0001) begin errors++; $display("FAIL lock_sel0 got %b exp 0001", core_dout_ready); end
      @(negedge clk);
      core_dout_valid = 4'b1000; core_dout_data[3*DW +: DW] = 16'hC003; id = 8'd3;
      checks++; if (dout_valid !== 1'b1 || dout_data !== 16'hB000) begin errors++; $display("FAIL lock_held got %b/%h exp 1/b000", dout_valid, dout_data); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (core_dout_ready !== 4'b0001) begin errors++; $display("FAIL lock_hold[%0d] got %b exp 0001", k, core_dout_ready); end
      end
      dout_ready = 1'b1;
      @(negedge clk);
      checks++; if (dout_valid !== 1'b0 || core_dout_ready !== 4'b0001) begin errors++; $display("FAIL lock_empty got %b/%b exp 0/0001", dout_valid, core_dout_ready); end
      @(negedge clk);
      checks++; if (core_dout_ready !== 4'b1000) begin errors++; $display("FAIL lock_switch got %b exp 1000", core_dout_ready); end
      @(negedge clk);
      core_dout_valid = '0;
      checks++; if (dout_valid !== 1'b1 || dout_data !== 16'hC003) begin errors++; $display("FAIL lock_core3 got %b/%h exp 1/c003", dout_valid, dout_data); end
      @(negedge clk);
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL lock_done got %b exp 0", dout_valid); end
      dout_ready = 1'b0;
   endtask

   task automatic test_idle;
      @(negedge clk);
      core_idle = 4'b1111; #1;
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL idle_all got %b exp 1", idle); end
      core_idle = 4'b0111; #1;
      checks++; if (idle !== 1'b0) begin errors++; $display("FAIL idle_core3 got %b exp 0", idle); end
      core_idle = 4'b1110; #1;
      checks++; if (idle !== 1'b0) begin errors++; $display("FAIL idle_core0 got %b exp 0", idle); end
      core_idle = 4'b1111;
      core_dout_valid = 4'b1000; core_dout_data[3*DW +: DW] = 16'hD000; dout_ready = 1'b0;
      @(negedge clk);
      core_dout_valid = '0;
      checks++; if (idle !== 1'b0 || dout_valid !== 1'b1) begin errors++; $display("FAIL idle_parked got %b/%b exp 0/1", idle, dout_valid); end
      dout_ready = 1'b1;
      @(negedge clk);
      dout_ready = 1'b0;
      checks++; if (idle !== 1'b1 || dout_valid !== 1'b0) begin errors++; $display("FAIL idle_drained got %b/%b exp 1/0", idle, dout_valid); end
   endtask

   task automatic test_param;
      int ids [0:3];
      ids[0] = 2; ids[1] = 7; ids[2] = 4; ids[3] = 3;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         id = 8'(ids[k]);
         @(negedge clk);
         checks++; if (param_rd !== exp_param(ids[k])) begin errors++; $display("FAIL param_id%0d got %h exp %h", ids[k], param_rd, exp_param(ids[k])); end
         if (k == 0) begin
            checks++; if (param_rd[6*PW +: PW] !== 13'h0ABC) begin errors++; $display("FAIL param_hori got %h exp 0abc", param_rd[6*PW +: PW]); end
         end
      end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      id = 8'd1;
      drive_stream(1, 16'hF001, 2, 99, 4, 99);
      checks++; if (dout_valid !== 1'b1 || core_dout_ready !== 4'b0000) begin errors++; $display("FAIL rmid_full got %b/%b exp 1/0000", dout_valid, core_dout_ready); end
      checks++; if (param_rd !== exp_param(1)) begin errors++; $display("FAIL rmid_param got %h exp %h", param_rd, exp_param(1)); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (dout_valid !== 1'b0 || param_rd !== '0) begin errors++; $display("FAIL rmid_rst got %b/%h exp 0/0", dout_valid, param_rd); end
      checks++; if (core_dout_ready !== 4'b0001) begin errors++; $display("FAIL rmid_ready got %b exp 0001", core_dout_ready); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (dout_valid !== 1'b0 || core_dout_ready !== 4'b0010) begin errors++; $display("FAIL rmid_after got %b/%b exp 0/0010", dout_valid, core_dout_ready); end
   endtask

   task automatic test_perf;
      logic [31:0] exp_b;
      logic [31:0] exp_s;
`ifdef CV_ROUTER_PERF_EN
      exp_b = 32'd4; exp_s = 32'd3;
`else
      exp_b = 32'd0; exp_s = 32'd0;
`endif
      @(negedge clk);
      rst = 1'b1; id = 8'd0;
      @(negedge clk);
      rst = 1'b0;
      drive_stream(0, 16'hE001, 4, 4, 20, 4);
      checks++; if (n_got !== 4) begin errors++; $display("FAIL perf_pops got %0d exp 4", n_got); end
      for (int k = 0; k < 4 && k < n_got; k++) begin
         checks++; if (got[k] !== 16'hE001 + 16'(k)) begin errors++; $display("FAIL perf_order[%0d] got %h exp %h", k, got[k], 16'hE001 + 16'(k)); end
      end
      checks++; if (perf_stalls !== exp_s) begin errors++; $display("FAIL perf_stalls got %0d exp %0d", perf_stalls, exp_s); end
      checks++; if (perf_beats !== exp_b) begin errors++; $display("FAIL perf_beats got %0d exp %0d", perf_beats, exp_b); end
   endtask

   initial begin
      test_reset();
      test_inbound();
      test_backpressure();
      test_sel_lock();
      test_idle();
      test_param();
      test_reset_mid();
      test_perf();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
